// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one pixel RAM between the scan read stream and renderer writes, with a tear-free front/back swap at vsync.
module fb_arbiter #(
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int DATA_W = 12
) (
  input  logic                     vga_clk,
  input  logic                     clr,
  input  logic                     vs,
  input  logic [COL_W-1:0]         scan_col,
  input  logic [ROW_W-1:0]         scan_row,
  output logic [DATA_W-1:0]        scan_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [COL_W-1:0]         wr_col,
  input  logic [ROW_W-1:0]         wr_row,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     front,
  output logic [ROW_W+COL_W:0]     mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;
  logic [0:0]           r_state;
  logic [ROW_W+COL_W:0] r_fetched;
  logic                 r_fetched_ok;
  logic                 r_rd_pend;
  logic                 r_vs_d;
  logic [ROW_W+COL_W:0] w_rd_addr;
  logic                 w_need_rd;
  logic                 w_vs_fall;
  assign w_rd_addr = {front, scan_row, scan_col};
  assign w_need_rd = !r_fetched_ok || (w_rd_addr != r_fetched);
  assign w_vs_fall = r_vs_d & ~vs;
  assign wr_ready  = !clr && !w_need_rd && (r_state == IDLE);
  assign mem_we    = wr_ready & wr_valid;
  assign mem_addr  = wr_ready ? {~front, wr_row, wr_col} : w_rd_addr;
  assign mem_wdata = wr_data;
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      r_state      <= IDLE;
      front        <= 1'b0;
      r_fetched    <= '0;
      r_fetched_ok <= 1'b0;
      r_rd_pend    <= 1'b0;
      scan_data    <= '0;
      swap_ack     <= 1'b0;
      r_vs_d       <= 1'b1;
    end else begin
      r_vs_d    <= vs;
      r_rd_pend <= w_need_rd;
      swap_ack  <= (r_state == ARMED) && w_vs_fall;
      if (r_rd_pend) scan_data <= mem_rdata;
      if (w_need_rd) r_fetched <= w_rd_addr;
      // A sync edge always forces a refetch, so the first cell after sync is fresh
      r_fetched_ok <= w_vs_fall ? 1'b0 : (r_fetched_ok | w_need_rd);
      if (r_state == ARMED && w_vs_fall) begin
        r_state <= IDLE;
        front   <= ~front;
      end else if (r_state == IDLE && swap_req) begin
        r_state <= ARMED;
      end
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed cycle-by-cycle checks of read priority, write path, swap, refetch and reset behaviour.
module tb_fb_arbiter;
  logic        clk = 1'b0;
  logic        clr, vs, wr_valid, swap_req;
  logic [6:0]  scan_col, wr_col;
  logic [5:0]  scan_row, wr_row;
  logic [11:0] wr_data, mem_rdata;
  logic [11:0] scan_data, mem_wdata;
  logic        wr_ready, swap_ack, front, mem_we;
  logic [13:0] mem_addr;
  int checks = 0;
  int errors = 0;

  fb_arbiter dut (
    .vga_clk(clk), .clr(clr), .vs(vs), .scan_col(scan_col), .scan_row(scan_row),
    .scan_data(scan_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col),
    .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .front(front), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] adr(input logic f, input logic [5:0] r, input logic [6:0] c);
    return {f, r, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; vs = 1'b1; wr_valid = 1'b1; swap_req = 1'b0;
    scan_row = 6'd2; scan_col = 7'd5; wr_row = 6'd7; wr_col = 7'd9;
    wr_data = 12'h123; mem_rdata = 12'h000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_we", mem_we, 0);
      chk("rst_ready", wr_ready, 0);
      chk("rst_front", front, 0);
      chk("rst_sdata", scan_data, 0);
      chk("rst_ack", swap_ack, 0);
      next();
    end
    // P0: first read after reset
    clr = 1'b0; mem_rdata = 12'h555;
    @(negedge clk);
    chk("p0_addr", mem_addr, adr(0, 2, 5));
    chk("p0_we", mem_we, 0);
    chk("p0_ready", wr_ready, 0);
    next();
    // P1: write path with stable scan address
    @(negedge clk);
    chk("wr_ready", wr_ready, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, adr(1, 7, 9));
    chk("wr_wdata", mem_wdata, 12'h123);
    next();
    // P2 (N): scan steps to (2,6), read beats write
    scan_col = 7'd6; mem_rdata = 12'h000;
    @(negedge clk);
    chk("p2_sdata", scan_data, 12'h555);
    chk("rp_ready", wr_ready, 0);
    chk("rp_we", mem_we, 0);
    chk("rp_addr", mem_addr, adr(0, 2, 6));
    next();
    mem_rdata = 12'hABC;
    @(negedge clk);
    chk("rp_n1_ready", wr_ready, 1);
    next();
    mem_rdata = 12'h000;
    @(negedge clk);
    chk("rp_n2_sdata", scan_data, 12'hABC);
    next();
    // P5: vs falls with no swap pending
    vs = 1'b0;
    @(negedge clk);
    chk("hold_sdata", scan_data, 12'hABC);
    chk("vf_ready", wr_ready, 1);
    next();
    @(negedge clk);
    chk("refetch_addr", mem_addr, adr(0, 2, 6));
    chk("refetch_ready", wr_ready, 0);
    chk("refetch_ack", swap_ack, 0);
    chk("refetch_front", front, 0);
    next();
    // P7: swap request mid-frame
    vs = 1'b1; swap_req = 1'b1;
    @(negedge clk);
    chk("sr_ready", wr_ready, 1);
    next();
    swap_req = 1'b0;
    @(negedge clk);
    chk("armed_ready", wr_ready, 0);
    chk("armed_we", mem_we, 0);
    next();
    @(negedge clk);
    chk("armed_ready2", wr_ready, 0);
    next();
    // P10: vs falls while armed
    vs = 1'b0;
    @(negedge clk);
    chk("vf_ack", swap_ack, 0);
    chk("vf_front", front, 0);
    chk("vf_armed_ready", wr_ready, 0);
    next();
    @(negedge clk);
    chk("sw_ack", swap_ack, 1);
    chk("sw_front", front, 1);
    chk("sw_addr", mem_addr, adr(1, 2, 6));
    chk("sw_ready", wr_ready, 0);
    next();
    vs = 1'b1; mem_rdata = 12'h777;
    @(negedge clk);
    chk("sw_ack_end", swap_ack, 0);
    chk("sw_front_hold", front, 1);
    chk("sw_wr_ready", wr_ready, 1);
    chk("sw_wr_addr", mem_addr, adr(0, 7, 9));
    chk("sw_wr_we", mem_we, 1);
    next();
    // P13: swap_req coincident with vs fall arms only
    mem_rdata = 12'h000; vs = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    chk("sw_sdata", scan_data, 12'h777);
    next();
    vs = 1'b1; swap_req = 1'b0;
    @(negedge clk);
    chk("co_ack", swap_ack, 0);
    chk("co_front", front, 1);
    chk("co_refetch", mem_addr, adr(1, 2, 6));
    next();
    @(negedge clk);
    chk("co_armed_ready", wr_ready, 0);
    next();
    // P16: reset while armed
    clr = 1'b1;
    @(negedge clk);
    chk("ra_ready", wr_ready, 0);
    chk("ra_we", mem_we, 0);
    next();
    clr = 1'b0;
    @(negedge clk);
    chk("ra_front", front, 0);
    chk("ra_ack", swap_ack, 0);
    chk("ra_addr", mem_addr, adr(0, 2, 6));
    next();
    vs = 1'b0;
    @(negedge clk);
    chk("ra_wr_ready", wr_ready, 1);
    chk("ra_wr_addr", mem_addr, adr(1, 7, 9));
    next();
    vs = 1'b1;
    @(negedge clk);
    chk("ra_no_ack", swap_ack, 0);
    chk("ra_front2", front, 0);
    chk("ra_refetch", mem_addr, adr(0, 2, 6));
    next();
    @(negedge clk);
    chk("ra_no_ack2", swap_ack, 0);
    chk("ra_wr_ready2", wr_ready, 1);
    next();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer arbiter and double-buffer swap controller. It shares one synchronous pixel RAM between the VGA scan engine's read stream and a renderer's write stream. The RAM holds two frames of coarse-pixel cells; the scan engine always reads the front frame and the renderer always writes the back frame. The arbiter exchanges front and back only at the start of vertical sync, so a displayed frame never tears.

## Interface
- `COL_W`, default 7: cell column address width (80 columns of 8-pixel cells).
- `ROW_W`, default 6: cell row address width (60 rows of 8-line cells).
- `DATA_W`, default 12: pixel word width, `{b,g,r}` 4 bits each.
- `vga_clk`  in  1  pixel clock; the only clock.
- `clr`  in  1  reset, synchronous and active-high.
- `vs`  in  1  vertical sync from the scan engine; low during sync pulse.
- `scan_col`  in  COL_W  registered cell column from the scan engine.
- `scan_row`  in  ROW_W  registered cell row from the scan engine.
- `scan_data`  out  DATA_W  registered pixel word for the scan engine's `din`.
- `wr_valid`  in  1  renderer write request.
- `wr_ready`  out  1  write accepted this cycle when `wr_valid & wr_ready`.
- `wr_col`  in  COL_W  write cell column, back frame.
- `wr_row`  in  ROW_W  write cell row, back frame.
- `wr_data`  in  DATA_W  write pixel word.
- `swap_req`  in  1  single-cycle pulse: the back frame is complete.
- `swap_ack`  out  1  single-cycle pulse: the swap has been performed.
- `front`  out  1  index of the frame currently displayed.
- `mem_addr`  out  1+ROW_W+COL_W  RAM address `{frame, row, col}`.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid 1 cycle after the address.

## Operation
- **Read fetch tracking.** `fetched` holds `{front,scan_row,scan_col}` of the last read issued, plus a `fetched_ok` flag.
- **Read need.** `need_rd = !fetched_ok || {front,scan_row,scan_col} != fetched`.
- **Per-cycle port grant (combinational from inputs and state).**
  - Read has priority. If `need_rd`: `mem_addr={front,scan_row,scan_col}`, `mem_we=0`, `wr_ready=0`; `fetched` is updated and `fetched_ok` set.
  - Otherwise, if the swap FSM is in IDLE: `wr_ready=1`. `mem_addr={~front,wr_row,wr_col}`, `mem_we=wr_valid`, `mem_wdata=wr_data`.
  - Otherwise: `wr_ready=0`, `mem_we=0`, `mem_addr` holds `{front,scan_row,scan_col}`.
- **Read return.** `rd_pend` is registered `need_rd`. When `rd_pend` is 1, `scan_data <= mem_rdata`; otherwise `scan_data` holds.
- **Swap FSM.**
  - States: IDLE, ARMED.
  - IDLE → ARMED on `swap_req`.
  - ARMED: writes are blocked (`wr_ready=0`); `swap_req` is ignored.
  - ARMED → IDLE on `vs_fall`, where `vs_fall = vs_d & !vs` and `vs_d` is registered `vs`. In that cycle: `front <= ~front`, `fetched_ok <= 0`, `swap_ack <= 1` (visible next cycle for exactly 1 cycle).
  - `swap_req` arriving in the same cycle as `vs_fall` while in IDLE arms only; no swap happens until the next `vs_fall`.
- **Frame boundary refetch.** `fetched_ok` also clears on every `vs_fall`. This forces a refetch of the first cell after sync, even without a swap.
- **Writer starvation.** Writer bandwidth is ≥7/8 of cycles when the scan address changes every 8 pixels. It is full bandwidth while the scan address is stable, e.g. during blanking. No writer fairness beyond this is provided.
- **Out-of-range addresses.** `wr_row`/`wr_col` beyond 59/79 are written as given; the arbiter does not clamp.

## Timing
- **Reset** (`clr` high at a clock edge):
  - State IDLE, `front=0`, `fetched_ok=0`, `rd_pend=0`, `scan_data=0`, `swap_ack=0`, `vs_d=1`.
  - While `clr` is high: `mem_we=0`, `wr_ready=0`.
  - First cycle after `clr` falls: a read is issued (`need_rd=1`).
- **Read latency.** Scan address change in cycle N → read issued in N → `mem_rdata` in N+1 → `scan_data` updated at edge ending N+1, visible in N+2. Fixed 2 cycles.
- **Write.** Accepted and issued to RAM in the same cycle as `wr_valid & wr_ready`; no buffering.
- **Swap.** `swap_ack` rises 1 cycle after the `vs_fall` cycle. `front` changes on that same edge. The first read of the new front frame is issued in the cycle `swap_ack` is high.
- **Reset mid-swap.** Clears ARMED; the swap request is lost, no `swap_ack` is generated, and `front` returns to 0.

## Test plan
- **Reset.** Hold `clr` 3 cycles, `wr_valid=1` → `mem_we=0`, `wr_ready=0`, `front=0`, `scan_data=0`. First post-reset cycle: `mem_addr={0,scan_row,scan_col}`, `mem_we=0`.
- **Read priority.** Scan (row,col) steps (2,5)→(2,6) at cycle N while `wr_valid=1` → `wr_ready=0` in N, `mem_addr={0,2,6}`. With RAM returning 12'hABC, `scan_data=12'hABC` in N+2. `wr_ready=1` in N+1.
- **Write path.** Stable scan address, `wr_valid=1`, `wr_row=7`, `wr_col=9`, `wr_data=12'h123`, `front=0` → same cycle: `mem_we=1`, `mem_addr={1,7,9}`, `mem_wdata=12'h123`, `wr_ready=1`.
- **Swap.** `swap_req` pulse mid-frame, then `vs` 1→0 → `wr_ready=0` from the cycle after `swap_req` until the swap. `swap_ack=1` for exactly 1 cycle, 1 cycle after `vs` falls. `front` becomes 1, and the next read is at `{1,row,col}`.
- **Refetch without swap.** `vs` falls with unchanged scan address and no swap pending → a read is issued at the same `{0,row,col}` in the following cycle.
- **Reset while ARMED.** `swap_req`, then `clr` before `vs` falls → no `swap_ack` on subsequent `vs` falls, `front=0`, writes accepted again.
